// File: rtl/sumador_restador_serial_pkg.sv
// Shared definitions for the serial add/subtract datapath and its sibling arithmetic blocks.
// Holds the controller state encoding, default geometry and a counter-width helper.
package sumador_restador_serial_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DIGIT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_e;

    // A single-digit operation still needs a one-bit counter to keep the ports legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sumador_restador_serial_digit.sv
// DIGIT-bit ripple-carry adder slice shared by the accumulate and negate phases.
module sumador_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] A,
    input  logic [DIGIT-1:0] B,
    input  logic             Ci,
    output logic [DIGIT-1:0] Sum,
    output logic             Cout
);

    logic [DIGIT:0] carry;

    assign carry[0] = Ci;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        assign Sum[gi]     = A[gi] ^ B[gi] ^ carry[gi];
        assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end

    assign Cout = carry[DIGIT];

endmodule

// File: rtl/sumador_restador_serial.sv
// Digit-serial unsigned adder/subtractor returning |A-B| for subtraction; a borrow
// triggers a second serial pass that two's-complements the result in place.
module sumador_restador_serial
    import sumador_restador_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             neg,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    if (WIDTH < 2) begin : g_bad_width
        $error("sumador_restador_serial: WIDTH must be at least 2");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("sumador_restador_serial: WIDTH must be a multiple of DIGIT");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   bx_q, bx_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               sel_q, sel_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    int                 base;
    logic               last_digit;
    logic [DIGIT-1:0]   dig_a;
    logic [DIGIT-1:0]   dig_b;
    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;

    assign base       = int'(cnt_q) * DIGIT;
    assign last_digit = (cnt_q == CNT_W'(N - 1));

    // NEG reuses the same slice adder as ~result + carry with a zero second operand.
    assign dig_a = (state_q == NEG) ? ~res_q[base +: DIGIT] : a_q[base +: DIGIT];
    assign dig_b = (state_q == NEG) ? '0 : bx_q[base +: DIGIT];

    sumador_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .A    (dig_a),
        .B    (dig_b),
        .Ci   (carry_q),
        .Sum  (dig_sum),
        .Cout (dig_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bx_d    = bx_q;
        res_d   = res_q;
        sel_d   = sel_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    bx_d    = B ^ {WIDTH{select}};
                    sel_d   = select;
                    carry_d = select;
                    cout_d  = 1'b0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                res_d[base +: DIGIT] = dig_sum;
                carry_d              = dig_cout;
                cnt_d                = cnt_q + 1'b1;
                if (last_digit) begin
                    cnt_d  = '0;
                    cout_d = dig_cout;
                    if (sel_q && !dig_cout) begin
                        carry_d = 1'b1;
                        state_d = NEG;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            NEG: begin
                res_d[base +: DIGIT] = dig_sum;
                carry_d              = dig_cout;
                cnt_d                = cnt_q + 1'b1;
                if (last_digit) begin
                    cnt_d   = '0;
                    neg_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            bx_q    <= '0;
            res_q   <= '0;
            sel_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            res_q   <= res_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = res_q;
    assign Cout      = cout_q;
    assign neg       = neg_q;
    assign zero      = (res_q == '0);

endmodule

// File: tb/tb_sumador_restador_serial.sv
// Directed bench for the serial adder/subtractor at 8x1 and 16x4 geometries.
module tb_sumador_restador_serial;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        neg;
        logic        zero;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, sel, out_valid, out_ready;
    logic [7:0]  a, b, s;
    logic        cout, neg, zero;

    logic        in_valid16, in_ready16, sel16, out_valid16, out_ready16;
    logic [15:0] a16, b16, s16;
    logic        cout16, neg16, zero16;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    sumador_restador_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .select(sel), .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .Cout(cout), .neg(neg), .zero(zero)
    );

    sumador_restador_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .select(sel16), .out_valid(out_valid16), .out_ready(out_ready16),
        .S(s16), .Cout(cout16), .neg(neg16), .zero(zero16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic sv, input int w, input int n);
        exp_t        e;
        logic [16:0] t;
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 1);
        if (!sv) begin
            t      = {1'b0, av} + {1'b0, bv};
            e.s    = t[15:0] & mask;
            e.cout = (w == 16) ? t[16] : t[w];
            e.neg  = 1'b0;
            e.lat  = n;
        end else if (av >= bv) begin
            e.s    = av - bv;
            e.cout = 1'b1;
            e.neg  = 1'b0;
            e.lat  = n;
        end else begin
            e.s    = bv - av;
            e.cout = 1'b0;
            e.neg  = 1'b1;
            e.lat  = 2 * n;
        end
        e.zero = (e.s == 16'd0);
        return e;
    endfunction

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic sv, input int hold);
        exp_t got;
        int   cyc;
        bit   busy_bad;
        sb.push_back(model({8'd0, av}, {8'd0, bv}, sv, 8, 8));
        a = av; b = bv; sel = sv; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sel = ~sv;
        cyc = 0; busy_bad = 0;
        while (!out_valid && cyc < 64) begin
            if (in_ready) busy_bad = 1;
            tick();
            cyc++;
        end
        got = sb.pop_front();
        $display("op A=%0d B=%0d sel=%0d -> S=%0d Cout=%0d neg=%0d zero=%0d lat=%0d",
                 av, bv, sv, s, cout, neg, zero, cyc);
        chk("in_ready_busy", busy_bad, 0);
        chk("latency", cyc, got.lat);
        chk("S", s, got.s[7:0]);
        chk("Cout", cout, got.cout);
        chk("neg", neg, got.neg);
        chk("zero", zero, got.zero);
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_S", s, got.s[7:0]);
            chk("hold_flags", {cout, neg, zero}, {got.cout, got.neg, got.zero});
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    task automatic abort_op(input logic [7:0] av, input logic [7:0] bv, input logic sv, input int edges);
        bit seen;
        a = av; b = bv; sel = sv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (edges - 1) tick();
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        $display("abort A=%0d B=%0d sel=%0d at edge %0d", av, bv, sv, edges);
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_S", s, 0);
        chk("abort_flags", {cout, neg, zero}, 3'b001);
        seen = 0;
        repeat (24) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("abort_no_stale", seen, 0);
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        exp_t got;
        int   cyc;
        sb.push_back(model(av, bv, sv, 16, 4));
        a16 = av; b16 = bv; sel16 = sv; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        cyc = 0;
        while (!out_valid16 && cyc < 64) begin
            tick();
            cyc++;
        end
        got = sb.pop_front();
        $display("op16 A=%04h B=%04h sel=%0d -> S=%04h Cout=%0d neg=%0d lat=%0d",
                 av, bv, sv, s16, cout16, neg16, cyc);
        chk("latency16", cyc, got.lat);
        chk("S16", s16, got.s);
        chk("flags16", {cout16, neg16, zero16}, {got.cout, got.neg, got.zero});
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        chk("release_valid16", out_valid16, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; sel16 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_ready", in_ready, 1);
        chk("reset_valid", out_valid, 0);
        chk("reset_S", s, 0);
        chk("reset_flags", {cout, neg, zero}, 3'b001);
        chk("reset_ready16", in_ready16, 1);
        chk("reset_S16", s16, 0);

        do_op(8'd200, 8'd100, 1'b0, 0);
        do_op(8'd100, 8'd200, 1'b1, 0);
        do_op(8'd5,   8'd5,   1'b1, 5);
        do_op(8'd255, 8'd1,   1'b0, 0);
        do_op(8'd0,   8'd255, 1'b1, 0);
        do_op(8'd77,  8'd13,  1'b1, 2);

        abort_op(8'd9,  8'd2,   1'b0, 3);
        do_op(8'd7, 8'd3, 1'b1, 0);
        abort_op(8'd10, 8'd200, 1'b1, 11);
        abort_op(8'd1,  8'd1,   1'b0, 9);

        op16(16'h0010, 16'h0100, 1'b1);
        op16(16'hFFFF, 16'h0002, 1'b0);
        op16(16'h1234, 16'h0234, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
